mem_line_engine: RTL and testbench

MEM_LINE_ENGINE -- requirements
Module: mem_line_engine

---
 rtl/mem_line_engine.sv | 165 ++++++++++++++++
 tb/tb_mem_line_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_engine.sv
// Line transfer engine between an L2 cache and word-addressed main memory.
// Optionally writes back a dirty victim line, then fetches the fill line
// with a pipelined read stream. Memory-side strobes, address and write data
// are all flop outputs.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; no memory traffic
// WB     | writing victim words 0..WORDS-1, one per cycle
// RD     | issuing reads of fill words 0..WORDS-1, one per cycle
// CAP    | capturing the last read word; strobes low
// DONE   | resp_valid pulse; back to IDLE next cycle
module mem_line_engine #(
  parameter int n      = 32,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 10,
  localparam int IDX_W  = $clog2(WORDS),
  localparam int LINE_W = ADDR_W - IDX_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_writeback,
  input  logic [LINE_W-1:0]     req_fill_line,
  input  logic [LINE_W-1:0]     req_wb_line,
  input  logic [WORDS*n-1:0]    req_wb_data,
  output logic                  resp_valid,
  output logic [WORDS*n-1:0]    resp_data,
  output logic                  L2_read_request,
  output logic                  L2_write_request,
  output logic [ADDR_W-1:0]     L2_word_address,
  output logic [n-1:0]          L2_wdata,
  input  logic [n-1:0]          L2_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_RD, S_CAP, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [LINE_W-1:0]    fill_q, fill_d, wb_line_q, wb_line_d;
  logic [WORDS*n-1:0]   wb_data_q, wb_data_d;
  logic                 rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [n-1:0]         wdata_q, wdata_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 pend_q;
  logic [IDX_W-1:0]     pend_idx_q;
  logic [WORDS*n-1:0]   resp_data_q;

  // The counter wraps naturally from WORDS-1 to 0 at each phase change.
  assign cnt_inc = cnt_q + 1'b1;

  // Next-state and next-output decode; memory-side outputs are registered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    wb_line_d    = wb_line_q;
    wb_data_d    = wb_data_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          fill_d    = req_fill_line;
          wb_line_d = req_wb_line;
          wb_data_d = req_wb_data;
          cnt_d     = '0;
          if (req_writeback) begin
            state_d = S_WB;
            wr_d    = 1'b1;
            addr_d  = {req_wb_line, {IDX_W{1'b0}}};
            wdata_d = req_wb_data[n-1:0];
          end else begin
            state_d = S_RD;
            rd_d    = 1'b1;
            addr_d  = {req_fill_line, {IDX_W{1'b0}}};
          end
        end
      end
      S_WB: begin
        cnt_d = cnt_inc;
        if (cnt_q == LAST) begin
          state_d = S_RD;
          rd_d    = 1'b1;
          addr_d  = {fill_q, {IDX_W{1'b0}}};
        end else begin
          wr_d    = 1'b1;
          addr_d  = {wb_line_q, cnt_inc};
          wdata_d = wb_data_q[int'(cnt_inc)*n +: n];
        end
      end
      S_RD: begin
        cnt_d = cnt_inc;
        if (cnt_q == LAST) begin
          state_d = S_CAP;
        end else begin
          rd_d   = 1'b1;
          addr_d = {fill_q, cnt_inc};
        end
      end
      S_CAP: begin
        state_d      = S_DONE;
        resp_valid_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latches and registered memory-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fill_q       <= '0;
      wb_line_q    <= '0;
      wb_data_q    <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      wb_line_q    <= wb_line_d;
      wb_data_q    <= wb_data_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Read data lags its strobe by one cycle; remember which word is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      resp_data_q <= '0;
    end else begin
      pend_q     <= rd_q;
      pend_idx_q <= addr_q[IDX_W-1:0];
      if (pend_q) resp_data_q[int'(pend_idx_q)*n +: n] <= L2_rdata;
    end
  end

  assign req_ready        = (state_q == S_IDLE);
  assign resp_valid       = resp_valid_q;
  assign resp_data        = resp_data_q;
  assign L2_read_request  = rd_q;
  assign L2_write_request = wr_q;
  assign L2_word_address  = addr_q;
  assign L2_wdata         = wdata_q;

endmodule

// File: tb/tb_mem_line_engine.sv
// Bench for mem_line_engine: memory model, table of directed line transfers,
// hand sequences for ignored requests and mid-transfer reset, and random
// transfers checked against a line-level reference memory.
module tb_mem_line_engine;
  localparam int N  = 32;
  localparam int W  = 4;
  localparam int AW = 10;
  localparam int LW = 8;

  typedef struct {
    int            cyc;
    bit            w;
    logic [AW-1:0] a;
    logic [N-1:0]  d;
  } ev_t;

  typedef struct {
    bit              wb;
    logic [LW-1:0]   fl;
    logic [LW-1:0]   wl;
    logic [W*N-1:0]  wd;
    int              lat;
    logic [AW-1:0]   rd_a0;
    logic [W*N-1:0]  exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_writeback;
  logic [LW-1:0]   req_fill_line;
  logic [LW-1:0]   req_wb_line;
  logic [W*N-1:0]  req_wb_data;
  logic            resp_valid;
  logic [W*N-1:0]  resp_data;
  logic            L2_read_request;
  logic            L2_write_request;
  logic [AW-1:0]   L2_word_address;
  logic [N-1:0]    L2_wdata;
  logic [N-1:0]    L2_rdata = '0;

  logic [N-1:0] mem     [0:(1<<AW)-1];
  logic [N-1:0] ref_mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;
  bit prev_resp = 1'b0;

  mem_line_engine #(.n(N), .WORDS(W), .ADDR_W(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_writeback    (req_writeback),
    .req_fill_line    (req_fill_line),
    .req_wb_line      (req_wb_line),
    .req_wb_data      (req_wb_data),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .L2_read_request  (L2_read_request),
    .L2_write_request (L2_write_request),
    .L2_word_address  (L2_word_address),
    .L2_wdata         (L2_wdata),
    .L2_rdata         (L2_rdata)
  );

  always #5 clk = ~clk;

  // Main memory: writes land on the strobe edge, read data appears next cycle.
  always @(posedge clk) begin
    if (L2_write_request) mem[L2_word_address] <= L2_wdata;
    if (L2_read_request) L2_rdata <= mem[L2_word_address];
    else                 L2_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous protocol checks.
  always @(negedge clk) begin
    chk("strobe_overlap", 128'(L2_read_request & L2_write_request), 0);
    if (req_ready) chk("idle_strobes", {L2_read_request, L2_write_request}, 0);
    if (resp_valid) chk("resp_one_cycle", 128'(prev_resp), 0);
    prev_resp = resp_valid;
  end

  // One line transaction, called at a negedge. Expected strobe trace, latency
  // and returned line come from the reference memory.
  task automatic run_txn(input bit wb, input logic [LW-1:0] fl, input logic [LW-1:0] wl,
                         input logic [W*N-1:0] wd, output int waited, output int lat,
                         output logic [AW-1:0] rd_a0, output logic [W*N-1:0] data);
    ev_t exp_q[$];
    ev_t act_q[$];
    ev_t e;
    int base, exp_lat;
    bit got, seen_rd;
    logic [W*N-1:0] exp_data;
    base = 0;
    exp_data = '0;
    if (wb) begin
      for (int i = 0; i < W; i++) begin
        e.cyc = i + 1; e.w = 1'b1; e.a = {wl, 2'(i)}; e.d = wd[i*N +: N];
        exp_q.push_back(e);
        ref_mem[e.a] = e.d;
      end
      base = W;
    end
    for (int i = 0; i < W; i++) begin
      e.cyc = base + 1 + i; e.w = 1'b0; e.a = {fl, 2'(i)}; e.d = '0;
      exp_q.push_back(e);
      exp_data[i*N +: N] = ref_mem[e.a];
    end
    exp_lat = base + W + 2;

    req_writeback = wb; req_fill_line = fl; req_wb_line = wl; req_wb_data = wd;
    req_valid = 1'b1;
    waited = 0; lat = -1; rd_a0 = '0; data = '0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept", 128'(req_ready), 1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_writeback = 1'($urandom);
    req_fill_line = 8'($urandom);
    req_wb_line = 8'($urandom);
    req_wb_data = {$urandom, $urandom, $urandom, $urandom};
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (k > 1) @(negedge clk);
      if (L2_read_request || L2_write_request) begin
        e.cyc = k; e.w = L2_write_request; e.a = L2_word_address;
        e.d = L2_write_request ? L2_wdata : '0;
        act_q.push_back(e);
      end
      if (resp_valid) begin
        got = 1'b1; lat = k; data = resp_data;
      end
    end
    chk("resp_seen", 128'(got), 1);
    chk("n_strobes", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk("strobe_cycle", act_q[i].cyc, exp_q[i].cyc);
      chk("strobe_kind", 128'(act_q[i].w), 128'(exp_q[i].w));
      chk("strobe_addr", act_q[i].a, exp_q[i].a);
      chk("strobe_wdata", act_q[i].d, exp_q[i].d);
    end
    seen_rd = 1'b0;
    foreach (act_q[i]) if (!act_q[i].w && !seen_rd) begin
      rd_a0 = act_q[i].a; seen_rd = 1'b1;
    end
    chk("latency", lat, exp_lat);
    chk("resp_data", data, exp_data);
    if (wb) for (int i = 0; i < W; i++)
      chk("mem_wb", mem[{wl, 2'(i)}], ref_mem[{wl, 2'(i)}]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int waited, lat, gap;
    logic [AW-1:0] a0;
    logic [W*N-1:0] data, rwd;
    bit wb;
    logic [LW-1:0] fl, wl;

    for (int k = 0; k < (1 << AW); k++) begin
      mem[k] = 32'h1000 + k;
      ref_mem[k] = 32'h1000 + k;
    end

    vecs[0] = '{wb:1'b0, fl:8'd5, wl:8'd0, wd:'0, lat:6, rd_a0:10'd20,
                exp:{32'h1017, 32'h1016, 32'h1015, 32'h1014}};
    vecs[1] = '{wb:1'b1, fl:8'd7, wl:8'd2, wd:{32'hA3, 32'hA2, 32'hA1, 32'hA0}, lat:10,
                rd_a0:10'd28, exp:{32'h101F, 32'h101E, 32'h101D, 32'h101C}};
    vecs[2] = '{wb:1'b1, fl:8'd3, wl:8'd3, wd:{32'hB3, 32'hB2, 32'hB1, 32'hB0}, lat:10,
                rd_a0:10'd12, exp:{32'hB3, 32'hB2, 32'hB1, 32'hB0}};
    vecs[3] = '{wb:1'b0, fl:8'd2, wl:8'd9, wd:'0, lat:6, rd_a0:10'd8,
                exp:{32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    vecs[4] = '{wb:1'b0, fl:8'd255, wl:8'd0, wd:'0, lat:6, rd_a0:10'd1020,
                exp:{32'h13FF, 32'h13FE, 32'h13FD, 32'h13FC}};

    // Reset with a request pending: it must be ignored.
    reset = 1'b0;
    req_valid = 1'b1; req_writeback = 1'b1;
    req_fill_line = 8'd1; req_wb_line = 8'd1; req_wb_data = '1;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {L2_read_request, L2_write_request}, 0);
    chk("rst_addr", L2_word_address, 0);
    chk("rst_wdata", L2_wdata, 0);
    chk("rst_resp_valid", 128'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_ready", 128'(req_ready), 1);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 128'(req_ready), 1);

    // Directed table; entries after the first are issued from DONE.
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].wb, vecs[i].fl, vecs[i].wl, vecs[i].wd, waited, lat, a0, data);
      chk("tbl_wait", waited, (i == 0) ? 0 : 1);
      chk("tbl_latency", lat, vecs[i].lat);
      chk("tbl_rd_addr0", a0, vecs[i].rd_a0);
      chk("tbl_data", data, vecs[i].exp);
      if (vecs[i].wb) for (int j = 0; j < W; j++)
        chk("tbl_mem", mem[{vecs[i].wl, 2'(j)}], vecs[i].wd[j*N +: N]);
    end

    // Request pulsed during RD must be dropped.
    @(negedge clk);
    fork
      run_txn(1'b0, 8'd9, 8'd0, '0, waited, lat, a0, data);
      begin
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_writeback = 1'b0; req_fill_line = 8'd200;
        chk("busy_ready", 128'(req_ready), 0);
        @(negedge clk);
        req_valid = 1'b0;
      end
    join
    chk("busy_data", data, {32'h1027, 32'h1026, 32'h1025, 32'h1024});
    repeat (3) begin
      @(negedge clk);
      chk("no_queued", 128'(req_ready), 1);
    end

    // Reset in the second writeback cycle.
    rwd = {$urandom, $urandom, $urandom, $urandom};
    req_writeback = 1'b1; req_wb_line = 8'd40; req_fill_line = 8'd41;
    req_wb_data = rwd; req_valid = 1'b1;
    chk("rst_pre_ready", 128'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_c1_write", 128'(L2_write_request), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_strobes", {L2_read_request, L2_write_request}, 0);
    chk("arst_addr", L2_word_address, 0);
    chk("arst_wdata", L2_wdata, 0);
    chk("arst_resp_valid", 128'(resp_valid), 0);
    chk("arst_resp_data", resp_data, 0);
    chk("arst_ready", 128'(req_ready), 1);
    req_valid = 1'b1; req_writeback = 1'b0; req_fill_line = 8'd50;
    repeat (2) @(negedge clk);
    chk("arst_ignored", {L2_read_request, L2_write_request}, 0);
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("arst_no_resp", 128'(resp_valid), 0);
      chk("arst_idle", 128'(req_ready), 1);
    end
    chk("arst_mem_w0", mem[{8'd40, 2'd0}], rwd[31:0]);
    for (int j = 1; j < W; j++)
      chk("arst_mem_rest", mem[{8'd40, 2'(j)}], ref_mem[{8'd40, 2'(j)}]);
    ref_mem[{8'd40, 2'd0}] = rwd[31:0];
    run_txn(1'b0, 8'd40, 8'd0, '0, waited, lat, a0, data);
    chk("arst_refill", data[31:0], rwd[31:0]);

    // Random transfers, some back-to-back, some with aliased lines.
    for (int t = 0; t < 30; t++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      wb = 1'($urandom_range(0, 1));
      fl = 8'($urandom);
      wl = ($urandom_range(0, 3) == 0) ? fl : 8'($urandom);
      run_txn(wb, fl, wl, {$urandom, $urandom, $urandom, $urandom}, waited, lat, a0, data);
      chk("rnd_wait", waited, (gap == 0) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
